led_matrix_scan_ctrl: RTL

Column-scan sequencer for the 8x8 LED matrix datapath. It walks the column index and drives the one-hot column select. Each column gets a blanking gap, a programmable on-time (global brightness) and a programmable dwell. Front/back display-buffer swaps happen only at frame boundaries, so the shift-chain loader can refill the back buffer without tearing.

---
 rtl/led_matrix_scan_ctrl_if.sv | 40 ++++
 rtl/led_matrix_scan_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scan_ctrl_if.sv
// Signal bundle between the LED matrix scan controller and its host/datapath.
// With FRAME_CNT_EN defined the bundle also carries the 16-bit frame_count.
interface led_matrix_scan_ctrl_if #(
    parameter int NCOLS   = 8,
    parameter int DWELL_W = 8
);
    localparam int COL_W = $clog2(NCOLS);

    logic               enable;
    logic [DWELL_W-1:0] dwell_cfg;
    logic [DWELL_W-1:0] brightness;
    logic               swap_req;
    logic               swap_ack;
    logic               buf_sel;
    logic [COL_W-1:0]   col_idx;
    logic [NCOLS-1:0]   col_sel;
    logic               row_oe;
    logic               frame_start;
`ifdef FRAME_CNT_EN
    logic [15:0]        frame_count;

    modport master (
        output enable, dwell_cfg, brightness, swap_req,
        input  swap_ack, buf_sel, col_idx, col_sel, row_oe, frame_start, frame_count
    );
    modport slave (
        input  enable, dwell_cfg, brightness, swap_req,
        output swap_ack, buf_sel, col_idx, col_sel, row_oe, frame_start, frame_count
    );
`else
    modport master (
        output enable, dwell_cfg, brightness, swap_req,
        input  swap_ack, buf_sel, col_idx, col_sel, row_oe, frame_start
    );
    modport slave (
        input  enable, dwell_cfg, brightness, swap_req,
        output swap_ack, buf_sel, col_idx, col_sel, row_oe, frame_start
    );
`endif
endinterface

// File: rtl/led_matrix_scan_ctrl.sv
// Column-scan sequencer for the LED matrix: blank gap, on-time, dwell, and
// frame-boundary buffer swap. Optional FRAME_CNT_EN adds a frame counter.
module led_matrix_scan_ctrl #(
    parameter int NCOLS        = 8,
    parameter int BLANK_CYCLES = 4,
    parameter int DWELL_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    led_matrix_scan_ctrl_if.slave bus
);
    localparam int COL_W = $clog2(NCOLS);
    localparam int BLK_W = $clog2(BLANK_CYCLES + 1);
    localparam int CNT_W = (DWELL_W > BLK_W) ? DWELL_W : BLK_W;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(NCOLS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2,
        ST_OFF   = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [COL_W-1:0]   col_r, col_s;
    logic [DWELL_W-1:0] d_r, b_r, d_s, b_s;
    logic [DWELL_W-1:0] d_in_s, b_in_s;
    logic               buf_r, buf_s;
    logic               ack_r, ack_s;
    logic               fs_r, fs_s;
    logic               oe_r, oe_s;
    logic [NCOLS-1:0]   sel_r, sel_s;
    logic               col_end_s;

    function automatic logic [NCOLS-1:0] one_hot(input logic [COL_W-1:0] idx);
        one_hot = {{(NCOLS-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic [DWELL_W-1:0] eff_dwell(input logic [DWELL_W-1:0] cfg);
        eff_dwell = (cfg == {DWELL_W{1'b0}}) ? DWELL_W'(1'b1) : cfg;
    endfunction

    function automatic logic [DWELL_W-1:0] clamp_on(input logic [DWELL_W-1:0] bri,
                                                    input logic [DWELL_W-1:0] dwell);
        clamp_on = (bri > dwell) ? dwell : bri;
    endfunction

    // Next-state, column walk and buffer-swap decision.
    always_comb begin
        d_in_s    = eff_dwell(bus.dwell_cfg);
        b_in_s    = clamp_on(bus.brightness, d_in_s);
        state_s   = state_r;
        cnt_s     = cnt_r + CNT_W'(1'b1);
        col_s     = col_r;
        buf_s     = buf_r;
        ack_s     = 1'b0;
        fs_s      = 1'b0;
        col_end_s = 1'b0;

        // Config is captured on the first BLANK cycle and frozen for the column.
        if ((state_r == ST_BLANK) && (cnt_r == {CNT_W{1'b0}})) begin
            d_s = d_in_s;
            b_s = b_in_s;
        end else begin
            d_s = d_r;
            b_s = b_r;
        end

        case (state_r)
            ST_IDLE: begin
                cnt_s = {CNT_W{1'b0}};
                col_s = {COL_W{1'b0}};
                if (bus.enable) begin
                    state_s = ST_BLANK;
                    fs_s    = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BLANK: begin
                if (cnt_r == BLANK_LAST) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = (b_s != {DWELL_W{1'b0}}) ? ST_ON : ST_OFF;
                end else begin
                    state_s = ST_BLANK;
                end
            end
            ST_ON: begin
                if (cnt_r == CNT_W'(b_s) - CNT_W'(1'b1)) begin
                    cnt_s = {CNT_W{1'b0}};
                    if (d_s != b_s) begin
                        state_s = ST_OFF;
                    end else begin
                        col_end_s = 1'b1;
                    end
                end else begin
                    state_s = ST_ON;
                end
            end
            ST_OFF: begin
                if (cnt_r == CNT_W'(d_s - b_s) - CNT_W'(1'b1)) begin
                    cnt_s     = {CNT_W{1'b0}};
                    col_end_s = 1'b1;
                end else begin
                    state_s = ST_OFF;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
                col_s   = {COL_W{1'b0}};
            end
        endcase

        // The last cycle of the last column is the only point a swap may happen.
        if (col_end_s) begin
            state_s = ST_BLANK;
            col_s   = col_r + COL_W'(1'b1);
            if (col_r == COL_LAST) begin
                fs_s = 1'b1;
                if (bus.swap_req) begin
                    buf_s = ~buf_r;
                    ack_s = 1'b1;
                end else begin
                    buf_s = buf_r;
                end
            end else begin
                fs_s = 1'b0;
            end
        end else begin
            col_end_s = 1'b0;
        end

        if (!bus.enable) begin
            state_s = ST_IDLE;
            cnt_s   = {CNT_W{1'b0}};
            col_s   = {COL_W{1'b0}};
            buf_s   = buf_r;
            ack_s   = 1'b0;
            fs_s    = 1'b0;
        end else begin
            ack_s = ack_s;
        end

        oe_s  = (state_s == ST_ON);
        sel_s = (state_s == ST_ON) ? one_hot(col_s) : {NCOLS{1'b0}};
    end

    // State, counters and registered drive outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            col_r   <= {COL_W{1'b0}};
            d_r     <= DWELL_W'(1'b1);
            b_r     <= {DWELL_W{1'b0}};
            buf_r   <= 1'b0;
            ack_r   <= 1'b0;
            fs_r    <= 1'b0;
            oe_r    <= 1'b0;
            sel_r   <= {NCOLS{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            col_r   <= col_s;
            d_r     <= d_s;
            b_r     <= b_s;
            buf_r   <= buf_s;
            ack_r   <= ack_s;
            fs_r    <= fs_s;
            oe_r    <= oe_s;
            sel_r   <= sel_s;
        end
    end

    // Dropping enable must darken the matrix in the very same cycle.
    assign bus.col_sel     = bus.enable ? sel_r : {NCOLS{1'b0}};
    assign bus.row_oe      = bus.enable & oe_r;
    assign bus.col_idx     = col_r;
    assign bus.buf_sel     = buf_r;
    assign bus.swap_ack    = ack_r;
    assign bus.frame_start = fs_r;

`ifdef FRAME_CNT_EN
    logic [15:0] frame_cnt_r;

    // Counts frame_start pulses; survives enable aborts, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_r <= 16'd0;
        end else if (fs_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign bus.frame_count = frame_cnt_r;
`endif
endmodule
